// File: rtl/minitb_ahb_master_pipe.sv
// AHB-Lite master with a command queue and a two-stage address/data pipeline.
// Issues NONSEQ/SINGLE transfers back-to-back, honours wait states and the
// two-cycle ERROR response, and returns one in-order response per command.
// Misaligned or oversized commands are answered with an error and never reach the bus.
module minitb_ahb_master_pipe #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [1:0]            htrans,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [DATA_WIDTH-1:0] hrdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic                  rsp_error,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    localparam int PW       = $clog2(CMD_DEPTH);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam logic [PW:0] PTR_ONE       = 1;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    logic                  r_q_write [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_addr  [CMD_DEPTH];
    logic [2:0]            r_q_size  [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_wdata [CMD_DEPTH];
    logic [PW:0]           r_wr_ptr, r_rd_ptr;

    logic                  r_a_valid, r_a_write, r_cancel;
    logic [ADDR_WIDTH-1:0] r_a_addr;
    logic [2:0]            r_a_size;
    logic [DATA_WIDTH-1:0] r_a_wdata;
    logic [1:0]            r_htrans;
    logic                  r_d_valid, r_d_write;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic                  r_rej_pend, r_rej_write;
    logic                  r_rsp_valid, r_rsp_write, r_rsp_error;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_empty, w_full, w_push, w_pop;
    logic                  w_h_write, w_h_bad;
    logic [ADDR_WIDTH-1:0] w_h_addr, w_mask;
    logic [2:0]            w_h_size;
    logic [DATA_WIDTH-1:0] w_h_wdata;
    logic                  w_err_first, w_d_done, w_issue, w_reject;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push    = cmd_valid & ~w_full;

    assign w_h_write = r_q_write[r_rd_ptr[PW-1:0]];
    assign w_h_addr  = r_q_addr[r_rd_ptr[PW-1:0]];
    assign w_h_size  = r_q_size[r_rd_ptr[PW-1:0]];
    assign w_h_wdata = r_q_wdata[r_rd_ptr[PW-1:0]];
    assign w_mask    = ~({ADDR_WIDTH{1'b1}} << w_h_size);
    assign w_h_bad   = (w_h_size > 3'(MAX_SIZE)) || ((w_h_addr & w_mask) != '0);

    // A rejected head waits until A is empty so its response cannot overtake
    // an earlier command still on the bus.
    assign w_err_first = r_d_valid & hresp & ~hready;
    assign w_d_done    = r_d_valid & hready;
    assign w_issue     = hready & ~r_cancel & ~w_empty & ~w_h_bad;
    assign w_reject    = hready & ~r_cancel & ~w_empty & w_h_bad & ~r_a_valid & ~r_rej_pend;
    assign w_pop       = w_issue | w_reject;

    assign cmd_ready = ~w_full;
    assign htrans    = r_htrans;
    assign haddr     = r_a_addr;
    assign hwrite    = r_a_write;
    assign hsize     = r_a_size;
    assign hburst    = 3'b000;
    assign hwdata    = r_hwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_error = r_rsp_error;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = ~w_empty | r_a_valid | r_d_valid | r_rej_pend;

    // Queue storage; validity is tracked by the pointers alone.
    always_ff @(posedge hclk) begin
        if (w_push) begin
            r_q_write[r_wr_ptr[PW-1:0]] <= cmd_write;
            r_q_addr[r_wr_ptr[PW-1:0]]  <= cmd_addr;
            r_q_size[r_wr_ptr[PW-1:0]]  <= cmd_size;
            r_q_wdata[r_wr_ptr[PW-1:0]] <= cmd_wdata;
        end
    end

    // Queue pointers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Address and data stages, including the ERROR cancel / re-drive sequence.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_a_valid <= 1'b0;
            r_a_write <= 1'b0;
            r_a_addr  <= '0;
            r_a_size  <= '0;
            r_a_wdata <= '0;
            r_cancel  <= 1'b0;
            r_htrans  <= HTRANS_IDLE;
            r_d_valid <= 1'b0;
            r_d_write <= 1'b0;
            r_hwdata  <= '0;
        end else if (w_err_first) begin
            r_htrans <= HTRANS_IDLE;
            r_cancel <= r_a_valid;
        end else if (hready) begin
            if (r_cancel) begin
                // The cancelled A command stays put and goes back on the bus.
                r_d_valid <= 1'b0;
                r_htrans  <= HTRANS_NONSEQ;
                r_cancel  <= 1'b0;
            end else begin
                r_d_valid <= r_a_valid;
                r_d_write <= r_a_write;
                if (r_a_valid) r_hwdata <= r_a_write ? r_a_wdata : '0;
                if (w_issue) begin
                    r_a_valid <= 1'b1;
                    r_a_write <= w_h_write;
                    r_a_addr  <= w_h_addr;
                    r_a_size  <= w_h_size;
                    r_a_wdata <= w_h_wdata;
                    r_htrans  <= HTRANS_NONSEQ;
                end else begin
                    r_a_valid <= 1'b0;
                    r_htrans  <= HTRANS_IDLE;
                end
            end
        end
    end

    // Response register; a reject that meets a bus completion is held one cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
            r_rej_pend  <= 1'b0;
            r_rej_write <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
            if (w_d_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_write <= r_d_write;
                r_rsp_error <= hresp;
                r_rsp_rdata <= (!r_d_write && !hresp) ? hrdata : '0;
            end else if (r_rej_pend) begin
                r_rsp_valid <= 1'b1;
                r_rsp_write <= r_rej_write;
                r_rsp_error <= 1'b1;
            end else if (w_reject) begin
                r_rsp_valid <= 1'b1;
                r_rsp_write <= w_h_write;
                r_rsp_error <= 1'b1;
            end
            if (w_reject && w_d_done) begin
                r_rej_pend  <= 1'b1;
                r_rej_write <= w_h_write;
            end else if (!w_d_done) begin
                r_rej_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_minitb_ahb_master_pipe.sv
// Directed bench for minitb_ahb_master_pipe: single write, back-to-back reads,
// wait states, ERROR response, size/alignment rejects and mid-transfer reset.
module tb_minitb_ahb_master_pipe;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [31:0] hwdata;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic        rsp_valid, rsp_write, rsp_error;
    logic [31:0] rsp_rdata;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    minitb_ahb_master_pipe #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CMD_DEPTH(4)) u_dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_error(rsp_error),
        .rsp_rdata(rsp_rdata), .busy(busy)
    );

    always #5 hclk = ~hclk;

    // Slave model: read data is the address of the accepted address phase plus one.
    logic [7:0] sl_addr = 8'h00;
    always @(posedge hclk) begin
        if (hready && htrans == 2'b10) sl_addr <= haddr;
    end
    assign hrdata = {24'h0, sl_addr} + 32'd1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [2:0] s, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic w, input logic e, input logic [31:0] d);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
        if (v) begin
            chk({tag, "_write"}, 64'(rsp_write), 64'(w));
            chk({tag, "_error"}, 64'(rsp_error), 64'(e));
            chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(d));
        end
    endtask

    logic [7:0]  rd_haddr [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};
    logic [31:0] rd_data  [4] = '{32'h01, 32'h05, 32'h09, 32'h0D};
    int          rsp_cnt;

    initial begin
        hresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        tick();
        tick();
        chk("rst_htrans", 64'(htrans), 64'h0);
        chk("rst_haddr", 64'(haddr), 64'h0);
        chk("rst_hwrite", 64'(hwrite), 64'h0);
        chk("rst_hsize", 64'(hsize), 64'h0);
        chk("rst_hburst", 64'(hburst), 64'h0);
        chk("rst_hwdata", 64'(hwdata), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        hresetn = 1'b1;
        tick();

        // Single write.
        push(1'b1, 8'h10, 3'd2, 32'hDEADBEEF);
        tick();
        chk("wr_htrans", 64'(htrans), 64'h2);
        chk("wr_haddr", 64'(haddr), 64'h10);
        chk("wr_hwrite", 64'(hwrite), 64'h1);
        chk("wr_hsize", 64'(hsize), 64'h2);
        tick();
        chk("wr_hwdata", 64'(hwdata), 64'hDEADBEEF);
        chk("wr_busy", 64'(busy), 64'h1);
        chk("wr_early_rsp", 64'(rsp_valid), 64'h0);
        tick();
        chk_rsp("wr_rsp", 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("wr_busy_fall", 64'(busy), 64'h0);
        chk("wr_rsp_pulse", 64'(rsp_valid), 64'h0);
        tick();

        // Four reads queued under hready=0, then released back-to-back.
        hready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rd_ready_before_push", 64'(cmd_ready), 64'h1);
            push(1'b0, rd_haddr[i], 3'd2, 32'h0);
        end
        chk("rd_full_ready", 64'(cmd_ready), 64'h0);
        hready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 4) begin
                chk("rd_htrans", 64'(htrans), 64'h2);
                chk("rd_haddr", 64'(haddr), 64'(rd_haddr[k]));
            end else begin
                chk("rd_htrans_idle", 64'(htrans), 64'h0);
            end
            if (k == 0) chk("rd_ready_after_pop", 64'(cmd_ready), 64'h1);
            if (k >= 2 && k <= 5) chk_rsp("rd_rsp", 1'b1, 1'b0, 1'b0, rd_data[k-2]);
            else chk_rsp("rd_norsp", 1'b0, 1'b0, 1'b0, 32'h0);
        end
        tick();

        // Write then read with three wait states in the write's data phase.
        push(1'b1, 8'h20, 3'd2, 32'hCAFE0020);
        push(1'b0, 8'h24, 3'd2, 32'h0);
        tick();
        chk("ws_haddr0", 64'(haddr), 64'h24);
        chk("ws_hwdata0", 64'(hwdata), 64'hCAFE0020);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_htrans_hold", 64'(htrans), 64'h2);
            chk("ws_haddr_hold", 64'(haddr), 64'h24);
            chk("ws_hwdata_hold", 64'(hwdata), 64'hCAFE0020);
            chk("ws_no_rsp", 64'(rsp_valid), 64'h0);
        end
        hready = 1'b1;
        tick();
        chk_rsp("ws_wr_rsp", 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk_rsp("ws_rd_rsp", 1'b1, 1'b0, 1'b0, 32'h25);
        tick();
        tick();

        // Slave ERRORs the first of two writes.
        push(1'b1, 8'h30, 3'd2, 32'h11111111);
        push(1'b1, 8'h34, 3'd2, 32'h22222222);
        tick();
        chk("er_haddr_a", 64'(haddr), 64'h34);
        hresp  = 1'b1;
        hready = 1'b0;
        tick();
        chk("er_htrans_idle", 64'(htrans), 64'h0);
        chk("er_no_rsp", 64'(rsp_valid), 64'h0);
        hready = 1'b1;
        tick();
        chk_rsp("er_rsp", 1'b1, 1'b1, 1'b1, 32'h0);
        chk("er_redrive_htrans", 64'(htrans), 64'h2);
        chk("er_redrive_haddr", 64'(haddr), 64'h34);
        hresp = 1'b0;
        tick();
        chk("er_hwdata2", 64'(hwdata), 64'h22222222);
        chk("er_gap_rsp", 64'(rsp_valid), 64'h0);
        tick();
        chk_rsp("er_rsp2", 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("er_busy_done", 64'(busy), 64'h0);

        // Oversized then misaligned reads are rejected without bus activity.
        push(1'b0, 8'h00, 3'd3, 32'h0);
        chk("rj_htrans0", 64'(htrans), 64'h0);
        push(1'b0, 8'h02, 3'd2, 32'h0);
        chk_rsp("rj_rsp1", 1'b1, 1'b0, 1'b1, 32'h0);
        chk("rj_htrans1", 64'(htrans), 64'h0);
        tick();
        chk_rsp("rj_rsp2", 1'b1, 1'b0, 1'b1, 32'h0);
        chk("rj_htrans2", 64'(htrans), 64'h0);
        tick();
        chk("rj_no_rsp", 64'(rsp_valid), 64'h0);
        chk("rj_htrans3", 64'(htrans), 64'h0);
        chk("rj_busy", 64'(busy), 64'h0);

        // Reset with three commands queued and one in the data phase.
        push(1'b1, 8'h40, 3'd2, 32'h40404040);
        push(1'b1, 8'h44, 3'd2, 32'h44444444);
        push(1'b1, 8'h48, 3'd2, 32'h48484848);
        hready = 1'b0;
        push(1'b1, 8'h4C, 3'd2, 32'h4C4C4C4C);
        push(1'b1, 8'h50, 3'd2, 32'h50505050);
        chk("rs_pre_busy", 64'(busy), 64'h1);
        chk("rs_pre_hwdata", 64'(hwdata), 64'h40404040);
        #2;
        hresetn = 1'b0;
        #1;
        chk("rs_htrans", 64'(htrans), 64'h0);
        chk("rs_haddr", 64'(haddr), 64'h0);
        chk("rs_hwrite", 64'(hwrite), 64'h0);
        chk("rs_hwdata", 64'(hwdata), 64'h0);
        chk("rs_busy", 64'(busy), 64'h0);
        chk("rs_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rs_rsp_valid", 64'(rsp_valid), 64'h0);
        hready = 1'b1;
        tick();
        hresetn = 1'b1;
        rsp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) rsp_cnt++;
        end
        chk("rs_no_rsp_after", 64'(rsp_cnt), 64'h0);
        chk("rs_idle_after", 64'(htrans), 64'h0);
        chk("rs_ready_after", 64'(cmd_ready), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
